// File: rtl/poly_stream_tx_pkg.sv
// Shared constants and types for the ML-DSA polynomial stream source.
// Normalisation lives here so every consumer maps coefficients into [0,Q) identically.
package poly_stream_tx_pkg;

  localparam int N  = 256;
  localparam int Q  = 8380417;
  localparam int DW = 32;
  localparam int AW = 8;

  typedef logic signed [DW-1:0] coef_t;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} tx_state_t;

  // Out-of-range inputs go through the same rule unchecked.
  function automatic coef_t normalise(input coef_t x);
    return (x < 0) ? x + coef_t'(Q) : x;
  endfunction

endpackage

// File: rtl/poly_stream_tx_buf.sv
// N x DW simple dual-port coefficient buffer: one write port, one registered read port.
module poly_stream_tx_buf
  import poly_stream_tx_pkg::*;
(
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  coef_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output coef_t         rd_data
);

  coef_t mem [N];

  // NOTE: the array has no reset so it maps onto block RAM; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/poly_stream_tx.sv
// Buffers one polynomial and replays it as a single gap-free, normalised burst
// shaped for the ntt core's ready/data input.
module poly_stream_tx
  import poly_stream_tx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  coef_t         wr_data,
  input  logic          start,
  output logic          busy,
  output logic          ready,
  output coef_t         data,
  output logic          done,
  output logic          wr_err
);

  tx_state_t     state;
  logic [AW-1:0] rd_addr;
  logic          last_beat;
  coef_t         rd_data;
  logic          wr_accept;

  // Writes landing on the start edge are still accepted because busy rises one cycle later.
  assign wr_accept = wr_en && !busy;

  poly_stream_tx_buf u_buf (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: all state and outputs update with non-blocking assignments in one clocked block,
  // so every output is a register and nothing here can infer a latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_addr   <= '0;
      last_beat <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      data      <= '0;
      done      <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      ready <= 1'b0;
      data  <= '0;
      done  <= 1'b0;
      if (wr_en && busy) wr_err <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= PRIME;
            busy      <= 1'b1;
            wr_err    <= 1'b0;
            rd_addr   <= '0;
            last_beat <= 1'b0;
          end
        end
        PRIME: begin
          state   <= STREAM;
          rd_addr <= rd_addr + 1'b1;
        end
        STREAM: begin
          ready <= 1'b1;
          data  <= normalise(rd_data);
          // Counter saturates at N-1; the flag marks that the final address is already in flight.
          if (last_beat) begin
            state     <= DONE;
            last_beat <= 1'b0;
          end else if (rd_addr == AW'(N - 1)) begin
            last_beat <= 1'b1;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          rd_addr <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
